// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer: walks every input vector of a gate under test, waits a settle
// window, samples the gate output against an expected mask and reports pass/fail.
module gate_tt_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 3,
  parameter logic [2**N_IN-1:0] EXPECT = 4'b1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              dut_out,
  output logic [N_IN-1:0]   dut_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2**N_IN-1:0] fail_vec,
  output logic [N_IN:0]     err_count
);

  localparam int NV = 2**N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST = N_IN'(NV-1);
  localparam logic [CW-1:0]   CMAX = CW'(SETTLE-1);

  typedef enum logic [1:0] {IDLE, SETL, SMPL, DONE} state_t;

  state_t          state, state_d;
  logic [N_IN-1:0] vec, vec_d, dut_in_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            busy_d, done_d, pass_d, mism;
  logic [NV-1:0]   fail_d;
  logic [N_IN:0]   err_d, err_nxt;

  assign mism    = dut_out != EXPECT[vec];
  assign err_nxt = err_count + {{N_IN{1'b0}}, mism};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= '0;
      cnt       <= '0;
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_vec  <= '0;
      err_count <= '0;
    end else begin
      state     <= state_d;
      vec       <= vec_d;
      cnt       <= cnt_d;
      dut_in    <= dut_in_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      fail_vec  <= fail_d;
      err_count <= err_d;
    end
  end

  always_comb begin
    state_d  = state;
    vec_d    = vec;
    cnt_d    = cnt;
    dut_in_d = dut_in;
    busy_d   = busy;
    done_d   = done;
    pass_d   = pass;
    fail_d   = fail_vec;
    err_d    = err_count;
    if (abort) begin
      // partial fail_vec/err_count are kept so an aborted run can still be inspected
      state_d  = IDLE;
      vec_d    = '0;
      cnt_d    = '0;
      dut_in_d = '0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      pass_d   = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state_d  = SETL;
          vec_d    = '0;
          cnt_d    = '0;
          dut_in_d = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          fail_d   = '0;
          err_d    = '0;
        end
        SETL: begin
          if (cnt == CMAX) state_d = SMPL;
          else             cnt_d   = cnt + 1'b1;
        end
        SMPL: begin
          err_d = err_nxt;
          if (mism) fail_d[vec] = 1'b1;
          if (vec == LAST) begin
            state_d  = DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            pass_d   = (err_nxt == '0);
            dut_in_d = '0;
          end else begin
            state_d  = SETL;
            vec_d    = vec + 1'b1;
            dut_in_d = vec + 1'b1;
            cnt_d    = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Directed bench for gate_tt_sequencer: table of full runs against behavioural gate
// models, plus hand sequences for abort, start/abort collision and async reset.
module tb_gate_tt_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, dut_out;
  logic [1:0] dut_in;
  logic       busy, done, pass;
  logic [3:0] fail_vec;
  logic [2:0] err_count;
  logic [1:0] mode;  // 0 AND, 1 OR, 2 stuck-at-1

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      2'd0:    dut_out = dut_in[0] & dut_in[1];
      2'd1:    dut_out = dut_in[0] | dut_in[1];
      default: dut_out = 1'b1;
    endcase
  end

  gate_tt_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(dut_out),
    .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
    .fail_vec(fail_vec), .err_count(err_count)
  );

  typedef struct {
    logic [1:0] mode;
    logic       extra;  // pulse start at edges 5 and 9 mid-run
    logic       pass;
    logic [3:0] fv;
    logic [2:0] ec;
  } run_t;

  run_t runs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " dut_in"}, 32'(dut_in), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " pass"}, 32'(pass), 0);
    chk({tag, " fail_vec"}, 32'(fail_vec), 0);
    chk({tag, " err_count"}, 32'(err_count), 0);
  endtask

  // Edge 1 samples start; vector k is driven over edges 4k+1..4k+4; done at edge 17.
  task automatic do_run(input run_t r, input int idx);
    string t;
    t = $sformatf("run%0d", idx);
    mode  = r.mode;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s e%0d dut_in", t, k + 1), 32'(dut_in), 32'(k / 4));
      chk($sformatf("%s e%0d busy", t, k + 1), 32'(busy), 1);
      chk($sformatf("%s e%0d done", t, k + 1), 32'(done), 0);
      if (r.extra && (k == 3 || k == 7)) start = 1'b1;
      step();
      start = 1'b0;
    end
    chk({t, " done@17"}, 32'(done), 1);
    chk({t, " busy@17"}, 32'(busy), 0);
    chk({t, " dut_in@17"}, 32'(dut_in), 0);
    chk({t, " pass"}, 32'(pass), 32'(r.pass));
    chk({t, " fail_vec"}, 32'(fail_vec), 32'(r.fv));
    chk({t, " err_count"}, 32'(err_count), 32'(r.ec));
    step();
    step();
    chk({t, " done held"}, 32'(done), 1);
    chk({t, " pass held"}, 32'(pass), 32'(r.pass));
  endtask

  initial begin
    runs[0] = '{mode: 2'd0, extra: 1'b0, pass: 1'b1, fv: 4'b0000, ec: 3'd0};
    runs[1] = '{mode: 2'd1, extra: 1'b0, pass: 1'b0, fv: 4'b0110, ec: 3'd2};
    runs[2] = '{mode: 2'd2, extra: 1'b0, pass: 1'b0, fv: 4'b0111, ec: 3'd3};
    runs[3] = '{mode: 2'd0, extra: 1'b1, pass: 1'b1, fv: 4'b0000, ec: 3'd0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
    #12;
    chk_zero("reset");
    rst_n = 1'b1;
    step();
    chk("idle busy", 32'(busy), 0);

    // runs 2 and 3 restart directly from DONE
    for (int i = 0; i < 4; i++) do_run(runs[i], i);

    // abort while vector 01 settles: vector 00 already failed under stuck-at-1
    mode = 2'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 2; e <= 7; e++) step();
    chk("pre-abort dut_in", 32'(dut_in), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort pass", 32'(pass), 0);
    chk("abort dut_in", 32'(dut_in), 0);
    chk("abort fail_vec", 32'(fail_vec), 32'h1);
    chk("abort err_count", 32'(err_count), 1);
    step();
    step();
    chk("abort stays idle", 32'(busy), 0);

    // start and abort together: abort wins
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("collide busy", 32'(busy), 0);
    chk("collide fail_vec kept", 32'(fail_vec), 32'h1);

    // async reset while sampling vector 01
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 2; e <= 8; e++) step();
    chk("pre-reset busy", 32'(busy), 1);
    chk("pre-reset fail_vec", 32'(fail_vec), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async reset");
    #3;
    rst_n = 1'b1;
    step();
    do_run(runs[0], 4);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
